bcd_decimal_scan_decoder: RTL and testbench

Time-multiplexed BCD-to-decimal lamp driver for DIGITS packed BCD digits. It captures a digit word on a load strobe and scans one digit per slot. For the selected digit it drives a one-hot 10-line decimal output and a one-hot digit select. It adds dead-time anti-ghosting, blanking, sticky invalid-code detection and an optional leading-zero suppression feature. It sits between the lab counter/arithmetic datapaths and the board decimal-lamp/7-seg-style multiplexed displays.

---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_digit_decode.sv | 17 +
 rtl/bcd_decimal_scan_decoder.sv | 109 ++++++++++
 tb/tb_bcd_decimal_scan_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD decimal scan decoder: digit limit, lamp
// patterns and the prescaler count reserved as the anti-ghosting dead cycle.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX            = 4'd9;
  localparam logic [9:0] LAMPS_ALL_ACTIVE   = 10'h3FF;
  localparam logic [9:0] LAMPS_ALL_INACTIVE = 10'h000;
  localparam int         DEAD_CNT           = 0;

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational BCD nibble to active-high one-hot decimal decoder; codes
// above 9 give an all-zero pattern with valid low.
module bcd_digit_decode
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [9:0] onehot,
  output logic       valid
);

  always_comb begin
    valid  = (nibble <= BCD_MAX);
    onehot = LAMPS_ALL_INACTIVE;
    if (valid) onehot = 10'd1 << nibble;
  end

endmodule

// File: rtl/bcd_decimal_scan_decoder.sv
// Time-multiplexed BCD-to-decimal lamp driver with dead-time, blanking and
// sticky invalid-code flag. Define DECODER_LZB_EN for leading-zero blanking.
module bcd_decimal_scan_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int OUT_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  blank,
  input  logic                  err_clr,
  output logic [9:0]            out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  err,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CNT);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [9:0]        OUT_IDLE = (OUT_ACTIVE_LOW != 0) ? LAMPS_ALL_ACTIVE : LAMPS_ALL_INACTIVE;
  localparam logic [DIGITS-1:0] SEL_IDLE = (OUT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] shadow;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          cur_nibble;
  logic [9:0]          dig_onehot;
  logic                dig_valid;
  logic [DIGITS-1:0]   sel_hot;
  logic                load_bad;
  logic                suppress;
  logic                disp;
  logic [9:0]          out_next;
  logic [DIGITS-1:0]   sel_next;

  always_comb cur_nibble = shadow[{idx, 2'b00} +: 4];

  bcd_digit_decode u_decode (
    .nibble (cur_nibble),
    .onehot (dig_onehot),
    .valid  (dig_valid)
  );

  always_comb begin
    sel_hot  = '0;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_hot[i] = (idx == IDX_W'(i));
      if (bcd_in[4*i +: 4] > BCD_MAX) load_bad = 1'b1;
    end
  end

`ifdef DECODER_LZB_EN
  // A digit above 0 is blanked when it and every more-significant digit are zero.
  logic [DIGITS-1:0] lz_mask;
  always_comb begin
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run        = run & (shadow[4*i +: 4] == 4'd0);
      lz_mask[i] = run;
    end
  end
  always_comb suppress = |(lz_mask & sel_hot);
`else
  always_comb suppress = 1'b0;
`endif

  always_comb begin
    disp     = !blank && (cnt != CNT_DEAD) && !suppress;
    sel_next = disp ? sel_hot : '0;
    out_next = (disp && dig_valid) ? dig_onehot : '0;
  end

  // Outputs are built active-high and flipped to board polarity by XOR with the idle pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow     <= '0;
      cnt        <= '0;
      idx        <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      out        <= OUT_IDLE;
      digit_sel  <= SEL_IDLE;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) shadow <= bcd_in;
      if (load && load_bad) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;
      frame_done <= (cnt == CNT_DEAD) && (idx == '0);
      out        <= out_next ^ OUT_IDLE;
      digit_sel  <= sel_next ^ SEL_IDLE;
    end
  end

endmodule

// File: tb/tb_bcd_decimal_scan_decoder.sv
// Bench for bcd_decimal_scan_decoder: directed steps then random traffic,
// every cycle compared against a frame-position arithmetic model.
module tb_bcd_decimal_scan_decoder;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank;
  logic        err_clr;
  logic [9:0]  out;
  logic [3:0]  digit_sel;
  logic        err;
  logic        frame_done;

  int          n_checks;
  int          n_fail;
  int          m_t;
  int unsigned m_shadow;
  bit          m_err;
  logic [9:0]  exp_out;
  logic [3:0]  exp_sel;
  logic        exp_err;
  logic        exp_frame;

  bcd_decimal_scan_decoder #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .OUT_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .bcd_in     (bcd_in),
    .blank      (blank),
    .err_clr    (err_clr),
    .out        (out),
    .digit_sel  (digit_sel),
    .err        (err),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered outputs from the pre-edge model state, then advance the model.
  task automatic model_edge();
    int  p, slot, ph;
    int unsigned nib, higher;
    bit  show, bad;
    if (!rst_n) begin
      exp_out   = 10'h3FF;
      exp_sel   = 4'hF;
      exp_err   = 1'b0;
      exp_frame = 1'b0;
      m_t       = 0;
      m_shadow  = 0;
      m_err     = 1'b0;
    end else begin
      p         = m_t % FRAME;
      slot      = p / SCAN_DIV;
      ph        = p % SCAN_DIV;
      nib       = (m_shadow >> (4 * slot)) & 32'hF;
      higher    = m_shadow >> (4 * slot);
      exp_frame = (p == 0);
      exp_out   = 10'h3FF;
      exp_sel   = 4'hF;
      if (!blank && ph != 0) begin
        show = 1'b1;
`ifdef DECODER_LZB_EN
        if (slot > 0 && higher == 0) show = 1'b0;
`endif
        if (show) begin
          exp_sel = ~(4'b0001 << slot);
          if (nib <= 9) exp_out = ~(10'b1 << nib);
        end
      end
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
        if (((int'(bcd_in) >> (4 * i)) & 15) > 9) bad = 1'b1;
      if (load && bad)  m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      exp_err = m_err;
      if (load) m_shadow = {16'h0, bcd_in};
      m_t++;
    end
  endtask

  task automatic check_output();
    n_checks++;
    assert (out === exp_out) else begin
      n_fail++; $error("[TB] FAIL out t=%0d: observed %h expected %h", m_t, out, exp_out);
    end
    n_checks++;
    assert (digit_sel === exp_sel) else begin
      n_fail++; $error("[TB] FAIL digit_sel t=%0d: observed %h expected %h", m_t, digit_sel, exp_sel);
    end
    n_checks++;
    assert (err === exp_err) else begin
      n_fail++; $error("[TB] FAIL err t=%0d: observed %b expected %b", m_t, err, exp_err);
    end
    n_checks++;
    assert (frame_done === exp_frame) else begin
      n_fail++; $error("[TB] FAIL frame_done t=%0d: observed %b expected %b", m_t, frame_done, exp_frame);
    end
  endtask

  task automatic apply_stimulus();
    model_edge();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic check_const(input string tag, input logic [9:0] obs, input logic [9:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++; $error("[TB] FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_t      = 0;
    m_shadow = 0;
    m_err    = 1'b0;
    rst_n    = 1'b0;
    load     = 1'b0;
    bcd_in   = 16'h0;
    blank    = 1'b0;
    err_clr  = 1'b0;

    repeat (3) apply_stimulus();
    check_const("reset_out", out, 10'h3FF);
    check_const("reset_sel", {6'h0, digit_sel}, 10'h00F);

    rst_n = 1'b1; load = 1'b1; bcd_in = 16'h1239;
    apply_stimulus();
    load = 1'b0;
    apply_stimulus();
    check_const("slot0_digit9", out, 10'b01_1111_1111);
    check_const("slot0_sel", {6'h0, digit_sel}, 10'b00_0000_1110);
    repeat (34) apply_stimulus();

    load = 1'b1; bcd_in = 16'h12A4;
    apply_stimulus();
    load = 1'b0;
    repeat (16) apply_stimulus();
    err_clr = 1'b1;
    apply_stimulus();
    err_clr = 1'b0;
    apply_stimulus();
    load = 1'b1; bcd_in = 16'h00B0; err_clr = 1'b1;
    apply_stimulus();
    load = 1'b0; err_clr = 1'b0;
    apply_stimulus();

    load = 1'b1; bcd_in = 16'h4321;
    apply_stimulus();
    load = 1'b0;
    for (int k = 0; k < FRAME && (m_t % FRAME) != 5; k++) apply_stimulus();
    blank = 1'b1;
    repeat (5) apply_stimulus();
    blank = 1'b0;
    repeat (16) apply_stimulus();

    load = 1'b1; bcd_in = 16'h0070;
    apply_stimulus();
    load = 1'b0;
    repeat (16) apply_stimulus();
    load = 1'b1; bcd_in = 16'h0000;
    apply_stimulus();
    load = 1'b0;
    repeat (16) apply_stimulus();

    load = 1'b1; bcd_in = 16'h5678;
    apply_stimulus();
    load = 1'b0;
    for (int k = 0; k < FRAME && (m_t % FRAME) != 9; k++) apply_stimulus();
    rst_n = 1'b0;
    apply_stimulus();
    rst_n = 1'b1;
    repeat (17) apply_stimulus();

    for (int k = 0; k < 500; k++) begin
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < DIGITS; i++)
        w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 10));
      rst_n   = ($urandom_range(0, 59) != 0);
      load    = ($urandom_range(0, 7) == 0);
      bcd_in  = w;
      blank   = ($urandom_range(0, 9) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      apply_stimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
